mini68k_exc_ctrl: RTL and testbench
===================================

MINI68K_EXC_CTRL -- requirements
Module: mini68k_exc_ctrl

Interface
REQ-001 SHALL have parameter AUTOVEC_BASE, default 24, vector number of level-0 autovector (level n uses AUTOVEC_BASE+n).
REQ-002 SHALL have one clock and an asynchronous, active-low reset: clk input 1, rising-edge clock; rst_n input 1, asynchronous active-low reset.
REQ-003 irq_level  input  3  requested interrupt priority, 0 = none.
REQ-004 trap_req  input  1  core requests software/illegal exception this cycle; trap_vec  input  8  its vector number.
REQ-005 insn_boundary  input  1  core is at an instruction boundary and exceptions may be taken.
REQ-006 pc  input  32  return address to stack; sr_cur  input  16  current status register.
REQ-007 sr_in  output  16, sr_we  output  1  full-SR write port into the status register.
REQ-008 push_valid  output  1, push_data  output  16, push_ready  input  1  supervisor-stack word push handshake.
REQ-009 vec_req  output  1, vec_num  output  8, vec_ack  input  1, vec_data  input  32  vector-table read handshake.
REQ-010 new_pc  output  32, new_pc_valid  output  1  handler address to core; exc_busy  output  1  sequence in progress.
REQ-011 iack_level  output  3  level being acknowledged, valid while exc_busy for interrupts, else 0.

Function
REQ-012 SHALL implement states IDLE, SR_UPD, PUSH_PCL, PUSH_PCH, PUSH_SR, VEC_FETCH, JUMP.
REQ-013 In IDLE with insn_boundary=1, acceptance SHALL follow priority: trap_req, then pending interrupt, else stay IDLE.
REQ-014 Interrupt pending SHALL mean irq_level > sr_cur[10:8], or a level-7 edge (irq_level becomes 7 from a registered previous value other than 7) regardless of mask.
REQ-015 The level-7 edge SHALL be consumed when the interrupt is accepted; a held level 7 does not retrigger.
REQ-016 On acceptance, pc, sr_cur, kind (trap/irq), level and vector SHALL be latched; next state SR_UPD.
REQ-017 Vector SHALL be trap_vec for traps and AUTOVEC_BASE+level (8-bit, truncated) for interrupts.
REQ-018 SR_UPD SHALL last one cycle with sr_we=1, sr_in = latched SR with bit13=1, bit15=0, and for interrupts bits[10:8]=level (unchanged for traps).
REQ-019 PUSH_PCL, PUSH_PCH, PUSH_SR SHALL push latched pc[15:0], pc[31:16], latched original SR, in that order.
REQ-020 Each push SHALL hold push_valid=1 and stable push_data until a cycle with push_ready=1, then advance; push_ready ignored when push_valid=0.
REQ-021 VEC_FETCH SHALL hold vec_req=1 and stable vec_num until vec_ack=1, capturing vec_data that cycle.
REQ-022 JUMP SHALL last one cycle with new_pc_valid=1 and new_pc = captured vec_data, then return to IDLE.
REQ-023 exc_busy SHALL be 1 in every state except IDLE; trap_req, irq_level changes and insn_boundary SHALL not affect an active sequence (level-7 edge detector still updates).
REQ-024 Minimum latency acceptance to new_pc_valid SHALL be 6 cycles with push_ready and vec_ack tied high.
REQ-025 All outputs SHALL be registered or decoded from state only, with no combinational path from inputs.

Reset
REQ-026 On rst_n=0 the block SHALL asynchronously enter IDLE and drive sr_we, push_valid, vec_req, new_pc_valid, exc_busy=0, sr_in, push_data, vec_num, new_pc=0, iack_level=0.
REQ-027 The previous-level register SHALL reset to 0, so irq_level=7 held across reset release produces one edge.
REQ-028 Reset mid-sequence SHALL abort it without further pushes or SR writes.

Verification
REQ-029 sr_cur=16'h2000, irq_level=3, pc=32'h0000_1234, boundary pulse, ready/ack high -> sr_we with sr_in=16'h2300, pushes 16'h1234, 16'h0000, 16'h2000, vec_num=27, new_pc=vec_data 6 cycles after acceptance.
REQ-030 sr_cur=16'h2500, irq_level=4 -> no acceptance; raise to 6 -> accepted, sr_in=16'h2600, vec_num=30.
REQ-031 sr_cur=16'h2700, irq_level 0->7 -> accepted once, vec_num=31; hold 7, return SR to 16'h2700, boundary again -> not re-accepted.
REQ-032 trap_req with trap_vec=8'h20 and irq_level=5 > mask simultaneously, sr_cur=16'h8004 -> trap first, sr_in=16'h2004, vec_num=8'h20, iack_level=0; interrupt taken at next boundary.
REQ-033 push_ready low for 3 cycles during PUSH_PCH, vec_ack delayed 2 cycles -> push_data and vec_num stable throughout, no duplicate pushes, latency 11 cycles.
REQ-034 rst_n asserted during PUSH_SR -> all outputs 0 immediately, IDLE after release, no new_pc_valid.

Source files
------------

// File: rtl/mini68k_exc_ctrl.sv
// rtl/mini68k_exc_ctrl.sv - exception/interrupt sequencer: SR update, stack pushes, vector fetch, jump
// Outputs are decoded from the state register and latched context only.
module mini68k_exc_ctrl #(
    parameter int AUTOVEC_BASE = 24
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic [2:0]  irq_level,
    input  logic        trap_req,
    input  logic [7:0]  trap_vec,
    input  logic        insn_boundary,
    input  logic [31:0] pc,
    input  logic [15:0] sr_cur,
    output logic [15:0] sr_in,
    output logic        sr_we,
    output logic        push_valid,
    output logic [15:0] push_data,
    input  logic        push_ready,
    output logic        vec_req,
    output logic [7:0]  vec_num,
    input  logic        vec_ack,
    input  logic [31:0] vec_data,
    output logic [31:0] new_pc,
    output logic        new_pc_valid,
    output logic        exc_busy,
    output logic [2:0]  iack_level
);

    typedef enum logic [2:0] {
        IDLE, SR_UPD, PUSH_PCL, PUSH_PCH, PUSH_SR, VEC_FETCH, JUMP
    } state_t;

    state_t      state, state_nx;
    logic [31:0] pc_l, vec_data_l;
    logic [15:0] sr_l;
    logic        is_irq, nmi_pend;
    logic [2:0]  level_l, prev_level, irq_sel;
    logic [7:0]  vec_l, autovec;
    logic        nmi_edge, irq_above, irq_pend, take_trap, take_irq;

    // A level-7 edge stays pending until an interrupt is actually taken.
    assign nmi_edge  = (irq_level == 3'd7) && (prev_level != 3'd7);
    assign irq_above = irq_level > sr_cur[10:8];
    assign irq_pend  = irq_above || nmi_edge || nmi_pend;
    assign take_trap = (state == IDLE) && insn_boundary && trap_req;
    assign take_irq  = (state == IDLE) && insn_boundary && !trap_req && irq_pend;
    assign irq_sel   = irq_above ? irq_level : 3'd7;
    assign autovec   = 8'(AUTOVEC_BASE) + {5'b0, irq_sel};

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state      <= IDLE;
            pc_l       <= '0;
            sr_l       <= '0;
            is_irq     <= 1'b0;
            level_l    <= '0;
            vec_l      <= '0;
            vec_data_l <= '0;
            prev_level <= '0;
            nmi_pend   <= 1'b0;
        end else begin
            state      <= state_nx;
            prev_level <= irq_level;
            if (take_irq)
                nmi_pend <= 1'b0;
            else if (nmi_edge)
                nmi_pend <= 1'b1;
            if (take_trap || take_irq) begin
                pc_l    <= pc;
                sr_l    <= sr_cur;
                is_irq  <= take_irq;
                level_l <= take_irq ? irq_sel : 3'd0;
                vec_l   <= take_irq ? autovec : trap_vec;
            end
            if (state == VEC_FETCH && vec_ack)
                vec_data_l <= vec_data;
        end
    end

    always_comb begin
        state_nx = state;
        case (state)
            IDLE:      if (take_trap || take_irq) state_nx = SR_UPD;
            SR_UPD:    state_nx = PUSH_PCL;
            PUSH_PCL:  if (push_ready) state_nx = PUSH_PCH;
            PUSH_PCH:  if (push_ready) state_nx = PUSH_SR;
            PUSH_SR:   if (push_ready) state_nx = VEC_FETCH;
            VEC_FETCH: if (vec_ack) state_nx = JUMP;
            JUMP:      state_nx = IDLE;
            default:   state_nx = IDLE;
        endcase
    end

    always_comb begin
        sr_we        = 1'b0;
        sr_in        = '0;
        push_valid   = 1'b0;
        push_data    = '0;
        vec_req      = 1'b0;
        vec_num      = '0;
        new_pc_valid = 1'b0;
        new_pc       = '0;
        exc_busy     = (state != IDLE);
        iack_level   = (state != IDLE && is_irq) ? level_l : 3'd0;
        case (state)
            SR_UPD: begin
                sr_we = 1'b1;
                sr_in = {1'b0, sr_l[14], 1'b1, sr_l[12:11],
                         is_irq ? level_l : sr_l[10:8], sr_l[7:0]};
            end
            PUSH_PCL: begin
                push_valid = 1'b1;
                push_data  = pc_l[15:0];
            end
            PUSH_PCH: begin
                push_valid = 1'b1;
                push_data  = pc_l[31:16];
            end
            PUSH_SR: begin
                push_valid = 1'b1;
                push_data  = sr_l;
            end
            VEC_FETCH: begin
                vec_req = 1'b1;
                vec_num = vec_l;
            end
            JUMP: begin
                new_pc_valid = 1'b1;
                new_pc       = vec_data_l;
            end
            default: ;
        endcase
    end

endmodule

// File: tb/tb_mini68k_exc_ctrl.sv
// tb/tb_mini68k_exc_ctrl.sv - directed self-checking bench for mini68k_exc_ctrl
module tb_mini68k_exc_ctrl;

    logic        clk = 1'b0;
    logic        rst_n;
    logic [2:0]  irq_level;
    logic        trap_req;
    logic [7:0]  trap_vec;
    logic        insn_boundary;
    logic [31:0] pc;
    logic [15:0] sr_cur;
    logic [15:0] sr_in;
    logic        sr_we;
    logic        push_valid;
    logic [15:0] push_data;
    logic        push_ready;
    logic        vec_req;
    logic [7:0]  vec_num;
    logic        vec_ack;
    logic [31:0] vec_data;
    logic [31:0] new_pc;
    logic        new_pc_valid;
    logic        exc_busy;
    logic [2:0]  iack_level;

    int n_chk  = 0;
    int n_fail = 0;

    mini68k_exc_ctrl #(.AUTOVEC_BASE(24)) dut (
        .clk(clk), .rst_n(rst_n), .irq_level(irq_level), .trap_req(trap_req),
        .trap_vec(trap_vec), .insn_boundary(insn_boundary), .pc(pc), .sr_cur(sr_cur),
        .sr_in(sr_in), .sr_we(sr_we), .push_valid(push_valid), .push_data(push_data),
        .push_ready(push_ready), .vec_req(vec_req), .vec_num(vec_num), .vec_ack(vec_ack),
        .vec_data(vec_data), .new_pc(new_pc), .new_pc_valid(new_pc_valid),
        .exc_busy(exc_busy), .iack_level(iack_level)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_chk++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Caller has asserted the acceptance conditions in the current cycle (cycle 0).
    task automatic run_exc(input string nm, input logic [15:0] e_sr,
                           input logic [15:0] e_p0, input logic [15:0] e_p1,
                           input logic [15:0] e_p2, input logic [7:0] e_vec,
                           input logic [2:0] e_iack, input int stall_pch,
                           input int ack_wait, input int e_lat);
        int cyc = 0;
        int npush = 0;
        int nsrwe = 0;
        int stall = stall_pch;
        int aw = ack_wait;
        bit done = 1'b0;
        logic [15:0] ep [3];
        ep = '{e_p0, e_p1, e_p2};
        while (!done && cyc < 40) begin
            tick();
            insn_boundary = 1'b0;
            trap_req      = 1'b0;
            push_ready    = 1'b1;
            vec_ack       = 1'b0;
            cyc++;
            if (exc_busy) chk({nm, " iack_level"}, 32'(iack_level), 32'(e_iack));
            if (sr_we) begin
                nsrwe++;
                chk({nm, " sr_in"}, 32'(sr_in), 32'(e_sr));
            end
            if (push_valid) begin
                if (npush < 3) chk({nm, " push_data"}, 32'(push_data), 32'(ep[npush]));
                if (npush == 1 && stall > 0) begin
                    push_ready = 1'b0;
                    stall--;
                end
                if (push_ready) npush++;
            end
            if (vec_req) begin
                chk({nm, " vec_num"}, 32'(vec_num), 32'(e_vec));
                if (aw > 0) aw--;
                else vec_ack = 1'b1;
            end
            if (new_pc_valid) begin
                chk({nm, " new_pc"}, new_pc, vec_data);
                chk({nm, " latency"}, 32'(cyc), 32'(e_lat));
                done = 1'b1;
            end
        end
        if (!done) chk({nm, " timeout"}, 32'd0, 32'd1);
        chk({nm, " push count"}, 32'(npush), 32'd3);
        chk({nm, " sr_we count"}, 32'(nsrwe), 32'd1);
        tick();
        chk({nm, " idle after jump"}, 32'(exc_busy), 32'd0);
    endtask

    initial begin
        int cnt;
        rst_n = 1'b0; irq_level = 3'd0; trap_req = 1'b0; trap_vec = 8'h00;
        insn_boundary = 1'b0; pc = '0; sr_cur = 16'h2700; push_ready = 1'b1;
        vec_ack = 1'b1; vec_data = 32'h0000_4000;
        tick(); tick();
        chk("reset ctrl", {27'd0, sr_we, push_valid, vec_req, new_pc_valid, exc_busy}, 32'd0);
        chk("reset data", {sr_in, push_data}, 32'd0);
        chk("reset vec/pc", {21'd0, iack_level, vec_num} | new_pc, 32'd0);
        rst_n = 1'b1;
        tick(); tick();

        // masked-level interrupt 3 above mask 0
        sr_cur = 16'h2000; irq_level = 3'd3; pc = 32'h0000_1234; insn_boundary = 1'b1;
        run_exc("irq3", 16'h2300, 16'h1234, 16'h0000, 16'h2000, 8'd27, 3'd3, 0, 0, 6);
        irq_level = 3'd0;

        // level 4 under mask 5 is refused, level 6 is taken
        tick();
        sr_cur = 16'h2500; irq_level = 3'd4; insn_boundary = 1'b1;
        tick();
        insn_boundary = 1'b0;
        tick();
        chk("irq4 masked", 32'(exc_busy), 32'd0);
        irq_level = 3'd6; pc = 32'hABCD_0010; vec_data = 32'h0000_5000; insn_boundary = 1'b1;
        run_exc("irq6", 16'h2600, 16'h0010, 16'hABCD, 16'h2500, 8'd30, 3'd6, 0, 0, 6);
        irq_level = 3'd0;

        // level-7 edge under mask 7: taken once, held level does not retrigger
        tick(); tick();
        sr_cur = 16'h2700; irq_level = 3'd7; pc = 32'h0000_0700; vec_data = 32'h0000_7000;
        insn_boundary = 1'b1;
        run_exc("nmi", 16'h2700, 16'h0700, 16'h0000, 16'h2700, 8'd31, 3'd7, 0, 0, 6);
        insn_boundary = 1'b1;
        tick();
        insn_boundary = 1'b0;
        tick();
        chk("nmi held no retrigger", 32'(exc_busy), 32'd0);
        irq_level = 3'd0;

        // trap beats a simultaneous pending interrupt; interrupt follows
        tick();
        sr_cur = 16'h8004; irq_level = 3'd5; trap_req = 1'b1; trap_vec = 8'h20;
        pc = 32'h0000_0100; vec_data = 32'h0000_8000; insn_boundary = 1'b1;
        run_exc("trap", 16'h2004, 16'h0100, 16'h0000, 16'h8004, 8'h20, 3'd0, 0, 0, 6);
        sr_cur = 16'h2004; vec_data = 32'h0000_9000; insn_boundary = 1'b1;
        run_exc("irq5 after trap", 16'h2504, 16'h0100, 16'h0000, 16'h2004, 8'd29, 3'd5, 0, 0, 6);
        irq_level = 3'd0;

        // backpressure on the stack push and a slow vector read
        tick();
        sr_cur = 16'h2000; irq_level = 3'd2; pc = 32'h5555_AAAA; vec_data = 32'h00C0_FFEE;
        insn_boundary = 1'b1;
        run_exc("stall", 16'h2200, 16'hAAAA, 16'h5555, 16'h2000, 8'd26, 3'd2, 3, 2, 11);
        irq_level = 3'd0;

        // reset while pushing SR aborts the sequence
        tick();
        sr_cur = 16'h2000; irq_level = 3'd1; pc = 32'h0000_0042; insn_boundary = 1'b1;
        push_ready = 1'b1; vec_ack = 1'b1;
        tick();
        insn_boundary = 1'b0;
        tick(); tick(); tick();
        chk("abort in PUSH_SR", {15'd0, push_valid, push_data}, {15'd0, 1'b1, 16'h2000});
        rst_n = 1'b0;
        #1;
        chk("abort ctrl", {27'd0, sr_we, push_valid, vec_req, new_pc_valid, exc_busy}, 32'd0);
        chk("abort data", {sr_in, push_data}, 32'd0);
        chk("abort vec/pc", {21'd0, iack_level, vec_num} | new_pc, 32'd0);
        irq_level = 3'd0;
        tick();
        rst_n = 1'b1;
        cnt = 0;
        for (int i = 0; i < 8; i++) begin
            tick();
            cnt += int'(push_valid) + int'(new_pc_valid) + int'(sr_we) + int'(exc_busy);
        end
        chk("post-abort quiet", 32'(cnt), 32'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
